// File: rtl/fir_sample_source.sv
// fir_sample_source: paces 8-bit signed audio samples into the fir31 filter.
//
// A producer pushes samples into a DEPTH-entry FIFO. A free-running pacer
// produces one tick every CYCLES_PER_SAMPLE clocks while enabled. The cycle
// after each tick, the block presents one sample on x_out with a 1-cycle
// ready_out strobe. If the FIFO is empty at the tick, it still strobes: it
// sends a zero sample and flags an underflow. This keeps the FIR at a fixed rate.
//
// Ports
//   clk_in               in   system clock
//   rst_n_in             in   async active-low reset
//   enable_in            in   1 = run sample pacing, 0 = hold pacer idle
//   wr_valid_in          in   producer offers wr_data_in this cycle
//   wr_data_in           in   signed sample to enqueue
//   wr_ready_out         out  FIFO can accept (combinational from level)
//   ready_out            out  1-cycle strobe, x_out valid (fir31 ready_in)
//   x_out                out  current sample (fir31 x_in), held between strobes
//   level_out            out  FIFO occupancy
//   underflow_out        out  1-cycle pulse: strobe issued with FIFO empty
//   underflow_count_out  out  saturating underflow count

module fir_sample_source #(
    parameter int unsigned CYCLES_PER_SAMPLE = 64,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned UF_W              = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      enable_in,
    input  logic                      wr_valid_in,
    input  logic signed [7:0]         wr_data_in,
    output logic                      wr_ready_out,
    output logic                      ready_out,
    output logic signed [7:0]         x_out,
    output logic [$clog2(DEPTH):0]    level_out,
    output logic                      underflow_out,
    output logic [UF_W-1:0]           underflow_count_out
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_SAMPLE - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [UF_W-1:0]  UF_MAX   = {UF_W{1'b1}};

    // Storage and pointers
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;

    // Pacer
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;

    // Per-cycle control
    logic                     tick;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [LVL_W-1:0]         level_nxt;
    logic [UF_W-1:0]          uf_count_nxt;

    // Write acceptance depends only on the registered level. This keeps a full
    // FIFO refusing writes even when a pop happens in the same cycle.
    assign wr_ready_out = (level_out < LVL_FULL);

    // Pacer next-state and tick decode
    always_comb begin
        cnt_nxt = '0;
        tick    = 1'b0;
        if (enable_in) begin
            if (cnt == CNT_LAST) begin
                tick    = 1'b1;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // FIFO handshake and occupancy update. The pop is evaluated against the
    // pre-push level, so a push into an empty FIFO on a tick still underflows.
    always_comb begin
        fifo_empty = (level_out == '0);
        push       = wr_valid_in && wr_ready_out;
        pop        = tick && !fifo_empty;
        level_nxt  = level_out;
        unique case ({push, pop})
            2'b10:   level_nxt = level_out + LVL_W'(1);
            2'b01:   level_nxt = level_out - LVL_W'(1);
            default: level_nxt = level_out;
        endcase
    end

    // Saturating underflow counter next value
    always_comb begin
        uf_count_nxt = underflow_count_out;
        if (tick && fifo_empty && (underflow_count_out != UF_MAX)) begin
            uf_count_nxt = underflow_count_out + UF_W'(1);
        end
    end

    // Pacer counter register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // FIFO pointers and level. Pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_out <= level_nxt;
        end
    end

    // Sample storage. Contents need no reset because the pointers define validity.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_in;
        end
    end

    // Output strobe, sample and underflow reporting. On each tick the strobe
    // fires whether or not a sample is available.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ready_out           <= 1'b0;
            x_out               <= '0;
            underflow_out       <= 1'b0;
            underflow_count_out <= '0;
        end else begin
            ready_out           <= tick;
            underflow_out       <= tick && fifo_empty;
            underflow_count_out <= uf_count_nxt;
            if (tick) begin
                x_out <= pop ? mem[rd_ptr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_source.sv
// Bench for fir_sample_source. A queue-based reference model predicts every
// strobe. Expected strobes go into a scoreboard, and a separate monitor pops
// and compares them. UF_W is set to 2 so that counter saturation is reachable.

module tb_fir_sample_source;

    localparam int CPS    = 64;
    localparam int DEPTH  = 16;
    localparam int UF_W   = 2;
    localparam int UF_MAX = (1 << UF_W) - 1;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in = 1'b0;
    logic                   enable_in = 1'b0;
    logic                   wr_valid_in = 1'b0;
    logic signed [7:0]      wr_data_in = '0;
    logic                   wr_ready_out;
    logic                   ready_out;
    logic signed [7:0]      x_out;
    logic [4:0]             level_out;
    logic                   underflow_out;
    logic [UF_W-1:0]        underflow_count_out;

    fir_sample_source #(
        .CYCLES_PER_SAMPLE (CPS),
        .DEPTH             (DEPTH),
        .UF_W              (UF_W)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .enable_in           (enable_in),
        .wr_valid_in         (wr_valid_in),
        .wr_data_in          (wr_data_in),
        .wr_ready_out        (wr_ready_out),
        .ready_out           (ready_out),
        .x_out               (x_out),
        .level_out           (level_out),
        .underflow_out       (underflow_out),
        .underflow_count_out (underflow_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic signed [7:0] x;
        logic              uf;
        int                cnt;
    } exp_t;

    // Reference model state: these variables describe the DUT after the next edge
    logic signed [7:0] mq [$];
    exp_t              exp_q [$];
    logic signed [7:0] m_x = '0;
    int                m_cnt = 0;
    int                run = 0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus plus the model's view of the edge that consumes it
    task automatic cycle(input logic en, input logic v, input logic signed [7:0] d);
        bit full;
        bit tick;
        exp_t e;
        @(negedge clk_in);
        enable_in   = en;
        wr_valid_in = v;
        wr_data_in  = d;
        full = (mq.size() == DEPTH);
        tick = en && (((run + 1) % CPS) == 0);
        run  = en ? run + 1 : 0;
        if (tick) begin
            e.uf = 1'b0;
            if (mq.size() > 0) begin
                m_x = mq.pop_front();
            end else begin
                m_x  = '0;
                e.uf = 1'b1;
                if (m_cnt < UF_MAX) m_cnt++;
            end
            e.x   = m_x;
            e.cnt = m_cnt;
            exp_q.push_back(e);
        end
        if (v && !full) mq.push_back(d);
    endtask

    task automatic reset_dut();
        @(negedge clk_in);
        rst_n_in    = 1'b0;
        enable_in   = 1'b0;
        wr_valid_in = 1'b0;
        mq.delete();
        exp_q.delete();
        m_x   = '0;
        m_cnt = 0;
        run   = 0;
        #1;
        chk("rst_ready",    int'(ready_out), 0);
        chk("rst_x",        int'(x_out), 0);
        chk("rst_level",    int'(level_out), 0);
        chk("rst_uf",       int'(underflow_out), 0);
        chk("rst_ucnt",     int'(underflow_count_out), 0);
        chk("rst_wr_ready", int'(wr_ready_out), 1);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic idle(input logic en, input int n);
        for (int i = 0; i < n; i++) cycle(en, 1'b0, '0);
    endtask

    // Monitor: compares DUT outputs just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (ready_out) begin
                chk("strobe_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("strobe_x",    int'(x_out), int'(e.x));
                    chk("strobe_uf",   int'(underflow_out), int'(e.uf));
                    chk("strobe_ucnt", int'(underflow_count_out), e.cnt);
                end
            end else begin
                chk("uf_idle", int'(underflow_out), 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("strobe_missing", int'(ready_out), 1);
                end
            end
            chk("x_hold",   int'(x_out), int'(m_x));
            chk("level",    int'(level_out), mq.size());
            chk("wr_ready", int'(wr_ready_out), int'(mq.size() < DEPTH));
            chk("ucnt",     int'(underflow_count_out), m_cnt);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic en_r;
        int   pct;
        reset_dut();

        // Impulse: 0,0,1,0 at fixed spacing
        cycle(1'b0, 1'b1, 8'sd0);
        cycle(1'b0, 1'b1, 8'sd0);
        cycle(1'b0, 1'b1, 8'sd1);
        cycle(1'b0, 1'b1, 8'sd0);
        idle(1'b1, 4 * CPS + 2);

        // Full FIFO: the 17th write is dropped, then drain in order
        reset_dut();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 8'(i * 7 - 50));
        idle(1'b0, 3);
        idle(1'b1, DEPTH * CPS + 5);

        // Underflow on empty FIFO, then saturation of the 2-bit counter
        reset_dut();
        idle(1'b1, 3 * CPS + 2);
        idle(1'b1, 2 * CPS + 2);

        // Push into an empty FIFO on a tick cycle
        reset_dut();
        idle(1'b1, CPS - 1);
        cycle(1'b1, 1'b1, 8'sh55);
        idle(1'b1, CPS + 2);

        // Reset mid-operation with 5 entries pending
        reset_dut();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(-100 + i));
        idle(1'b1, 10);
        reset_dut();
        idle(1'b1, CPS + 2);

        // Randomized traffic with varying write rate and occasional enable drops
        reset_dut();
        en_r = 1'b1;
        pct  = 3;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) pct = (i % 1500 == 0) ? 1 : ((i % 1000 == 0) ? 10 : 3);
            if ($urandom_range(0, 299) == 0) en_r = ~en_r;
            if (i == 2000) reset_dut();
            cycle(en_r, 1'b1 && ($urandom_range(0, 99) < pct), 8'($urandom));
        end
        idle(1'b0, 2);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
